// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of an asynchronous clock over a fixed gate window
// of clk_src cycles and reports the count, range flags and a lock status.
module clk_freq_meter #(
    parameter int GATE_CYCLES  = 125000,
    parameter int EXPECT_COUNT = 3580,
    parameter int TOLERANCE    = 4,
    parameter int LOCK_WINDOWS = 3,
    parameter int CNT_W        = 24
) (
    input  logic             clk_src,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             too_slow,
    output logic             too_fast,
    output logic             no_clock,
    output logic             locked
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam int RW = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    // Lower bound clamps at zero when the tolerance exceeds the expected count.
    localparam logic [31:0] LO = (EXPECT_COUNT > TOLERANCE) ? 32'(EXPECT_COUNT - TOLERANCE) : 32'd0;
    localparam logic [31:0] HI = 32'(EXPECT_COUNT + TOLERANCE);

    typedef enum logic {M_IDLE, M_MEAS} meas_t;
    typedef enum logic [1:0] {L_UNLOCKED, L_ACQ, L_LOCKED} lock_t;

    logic [2:0]       sync_q;
    meas_t            meas_q, meas_d;
    lock_t            lock_q, lock_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edges_q, edges_d, count_q, count_d;
    logic [RW-1:0]    run_q, run_d;
    logic             valid_q, valid_d, slow_q, slow_d, fast_q, fast_d, none_q, none_d;

    logic             edge_det, last, in_range;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] result;
    logic [31:0]      res32;

    assign edge_det = sync_q[1] & ~sync_q[2];
    assign sum      = {1'b0, edges_q} + {{CNT_W{1'b0}}, edge_det};
    assign result   = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign res32    = 32'(result);
    assign in_range = (res32 >= LO) && (res32 <= HI);
    assign last     = (meas_q == M_MEAS) && (gate_q == GATE_LAST);

    always_comb begin
        meas_d  = meas_q;
        lock_d  = lock_q;
        gate_d  = gate_q;
        edges_d = edges_q;
        count_d = count_q;
        run_d   = run_q;
        valid_d = 1'b0;
        slow_d  = slow_q;
        fast_d  = fast_q;
        none_d  = none_q;
        if (meas_q == M_IDLE) begin
            gate_d  = '0;
            edges_d = '0;
            meas_d  = enable ? M_MEAS : M_IDLE;
        end else if (last) begin
            // A window always completes on its last cycle, even if enable just fell.
            gate_d  = '0;
            edges_d = '0;
            meas_d  = enable ? M_MEAS : M_IDLE;
            count_d = result;
            valid_d = 1'b1;
            slow_d  = res32 < LO;
            fast_d  = res32 > HI;
            none_d  = result == '0;
            if (in_range) begin
                run_d  = (lock_q == L_LOCKED) ? run_q : run_q + 1'b1;
                lock_d = (lock_q == L_LOCKED || int'(run_q) + 1 >= LOCK_WINDOWS) ? L_LOCKED : L_ACQ;
            end else begin
                run_d  = '0;
                lock_d = L_UNLOCKED;
            end
        end else if (!enable) begin
            meas_d  = M_IDLE;
            gate_d  = '0;
            edges_d = '0;
            run_d   = '0;
            lock_d  = L_UNLOCKED;
        end else begin
            gate_d  = gate_q + 1'b1;
            edges_d = result;
        end
    end

    always_ff @(posedge clk_src or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            meas_q  <= M_IDLE;
            lock_q  <= L_UNLOCKED;
            gate_q  <= '0;
            edges_q <= '0;
            count_q <= '0;
            run_q   <= '0;
            valid_q <= 1'b0;
            slow_q  <= 1'b0;
            fast_q  <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], clk_in};
            meas_q  <= meas_d;
            lock_q  <= lock_d;
            gate_q  <= gate_d;
            edges_q <= edges_d;
            count_q <= count_d;
            run_q   <= run_d;
            valid_q <= valid_d;
            slow_q  <= slow_d;
            fast_q  <= fast_d;
            none_q  <= none_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign too_slow = slow_q;
    assign too_fast = fast_q;
    assign no_clock = none_q;
    assign locked   = lock_q == L_LOCKED;
endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: directed bench for clk_freq_meter with a 100-cycle window,
// plus a 4-bit-counter instance for saturation.
module tb_clk_freq_meter;
    logic clk_src = 1'b0, reset = 1'b1, enable = 1'b1;
    logic gen_clk = 1'b0, man_clk = 1'b0, manual = 1'b0, sat_clk = 1'b0;
    logic clk_in;
    int   per = 10;
    logic [7:0] count;
    logic       valid, too_slow, too_fast, no_clock, locked;
    logic [3:0] s_count;
    logic       s_valid, s_slow, s_fast, s_none, s_locked;
    int         passed = 0, total = 0;

    assign clk_in = manual ? man_clk : gen_clk;

    clk_freq_meter #(.GATE_CYCLES(100), .EXPECT_COUNT(10), .TOLERANCE(1), .LOCK_WINDOWS(2), .CNT_W(8)) u_dut (
        .clk_src(clk_src), .reset(reset), .clk_in(clk_in), .enable(enable),
        .count(count), .valid(valid), .too_slow(too_slow), .too_fast(too_fast),
        .no_clock(no_clock), .locked(locked)
    );

    clk_freq_meter #(.GATE_CYCLES(100), .EXPECT_COUNT(10), .TOLERANCE(1), .LOCK_WINDOWS(2), .CNT_W(4)) u_sat (
        .clk_src(clk_src), .reset(reset), .clk_in(sat_clk), .enable(1'b1),
        .count(s_count), .valid(s_valid), .too_slow(s_slow), .too_fast(s_fast),
        .no_clock(s_none), .locked(s_locked)
    );

    initial forever #5 clk_src = ~clk_src;

    // per is the clk_in period in clk_src cycles; 0 holds clk_in low.
    initial forever begin
        if (per == 0) begin
            gen_clk = 1'b0;
            @(negedge clk_src);
        end else begin
            repeat (per / 2) @(negedge clk_src);
            gen_clk = ~gen_clk;
        end
    end

    initial forever begin
        repeat (2) @(negedge clk_src);
        sat_clk = ~sat_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_src);
            cyc++;
        end while (valid !== 1'b1 && cyc < budget);
        chk("valid_seen", 32'(valid), 1);
    endtask

    initial begin
        int cyc, seen, sum;
        repeat (3) @(negedge clk_src);
        chk("rst_count", 32'(count), 0);
        chk("rst_flags", 32'({valid, too_slow, too_fast, no_clock, locked}), 0);
        reset = 1'b0;
        wait_valid(120, cyc);
        chk("w1_locked", 32'(locked), 0);
        wait_valid(120, cyc);
        chk("w2_interval", 32'(cyc), 100);
        chk("w2_count", 32'(count), 10);
        chk("w2_locked", 32'(locked), 1);
        chk("w2_flags", 32'({too_slow, too_fast, no_clock}), 0);
        chk("sat_valid", 32'(s_valid), 1);
        chk("sat_count", 32'(s_count), 15);
        chk("sat_fast", 32'(s_fast), 1);
        @(negedge clk_src);
        chk("valid_pulse", 32'(valid), 0);
        // Now at gate 1; drop enable at gate 50.
        repeat (49) @(negedge clk_src);
        enable = 1'b0;
        seen = 0;
        repeat (150) begin
            @(negedge clk_src);
            if (valid) seen++;
        end
        chk("abort_no_valid", 32'(seen), 0);
        chk("abort_locked", 32'(locked), 0);
        chk("abort_count", 32'(count), 10);
        enable = 1'b1;
        wait_valid(120, cyc);
        chk("reen_interval", 32'(cyc), 101);
        chk("reen_count", 32'(count), 10);
        chk("reen_locked", 32'(locked), 0);
        wait_valid(120, cyc);
        chk("relock", 32'(locked), 1);
        per = 0;
        wait_valid(120, cyc);
        wait_valid(120, cyc);
        chk("dead_count", 32'(count), 0);
        chk("dead_flags", 32'({no_clock, too_slow, too_fast}), 3'b110);
        chk("dead_locked", 32'(locked), 0);
        per = 10;
        wait_valid(120, cyc);
        chk("rec1_range", 32'(count >= 9 && count <= 11), 1);
        chk("rec1_locked", 32'(locked), 0);
        wait_valid(120, cyc);
        chk("rec2_count", 32'(count), 10);
        chk("rec2_locked", 32'(locked), 1);
        // Period 8 gives 12 or 13 edges per window depending on phase.
        per = 8;
        wait_valid(120, cyc);
        wait_valid(120, cyc);
        chk("fast_count", 32'(count >= 12 && count <= 13), 1);
        chk("fast_flags", 32'({too_slow, too_fast, no_clock}), 3'b010);
        chk("fast_locked", 32'(locked), 0);
        per = 14;
        wait_valid(120, cyc);
        wait_valid(120, cyc);
        chk("slow_count", 32'(count >= 7 && count <= 8), 1);
        chk("slow_flags", 32'({too_slow, too_fast, no_clock}), 3'b100);
        per = 10;
        repeat (30) @(negedge clk_src);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_flags", 32'({valid, too_slow, too_fast, no_clock, locked}), 0);
        repeat (3) @(negedge clk_src);
        reset = 1'b0;
        wait_valid(120, cyc);
        chk("post_rst_interval", 32'(cyc), 101);
        // Edge on the last gate cycle of N, then one on the first cycle of N+2.
        manual = 1'b1;
        man_clk = 1'b0;
        wait_valid(120, cyc);
        repeat (97) @(negedge clk_src);
        man_clk = 1'b1;
        @(negedge clk_src);
        man_clk = 1'b0;
        wait_valid(120, cyc);
        chk("bnd_n", 32'(count), 1);
        sum = int'(count);
        repeat (98) @(negedge clk_src);
        man_clk = 1'b1;
        @(negedge clk_src);
        man_clk = 1'b0;
        wait_valid(120, cyc);
        chk("bnd_n1", 32'(count), 0);
        sum += int'(count);
        wait_valid(120, cyc);
        chk("bnd_n2", 32'(count), 1);
        sum += int'(count);
        chk("bnd_sum", 32'(sum), 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
